// File: rtl/bpu_pkg.sv
// bpu_pkg: shared history-mode and counter encodings plus the 2-bit saturating update
package bpu_pkg;
  typedef enum logic {MODE_LOCAL = 1'b0, MODE_GSHARE = 1'b1} bpu_mode_e;
  typedef enum logic [1:0] {SNT = 2'd0, WNT = 2'd1, WT = 2'd2, ST = 2'd3} ctr_e;
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    return taken ? ((ctr == 2'(ST)) ? 2'(ST) : ctr + 2'd1)
                 : ((ctr == 2'(SNT)) ? 2'(SNT) : ctr - 2'd1);
  endfunction
endpackage

// File: rtl/bpu_pht.sv
// bpu_pht: 2-bit saturating counter table, async read, sync read-modify-write training port
module bpu_pht
  import bpu_pkg::*;
#(
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] ridx_i,
  output logic [1:0]       rctr_o,
  input  logic             we_i,
  input  logic [IDX_W-1:0] widx_i,
  input  logic             taken_i
);
  localparam int N = 1 << IDX_W;
  logic [1:0] ctr_q [N];
  assign rctr_o = ctr_q[ridx_i];
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) ctr_q[i] <= 2'(WNT);
    end else if (we_i) begin
      ctr_q[widx_i] <= sat_update(ctr_q[widx_i], taken_i);
    end
  end
endmodule

// File: rtl/branch_predict_gen.sv
// branch_predict_gen: local/gshare 2-bit predictor with speculative GHR and E-stage repair.
// Define BPU_BTB_EN to add a direct-mapped BTB that gates taken predictions on a tag hit.
module branch_predict_gen
  import bpu_pkg::*;
#(
  parameter int PHT_IDX_W = 10,
  parameter int BHT_IDX_W = 8,
  parameter int HIST_W    = 8,
  parameter int BTB_IDX_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode,
  input  logic [31:0] pcF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        flushE,
  input  logic        branchD,
  input  logic        actual_takeE,
  input  logic [31:0] targetE,
  output logic        pred_takeD,
  output logic [31:0] pred_targetD,
  output logic        pred_hitD,
  output logic        pred_takeE,
  output logic        mispredictE
);
  localparam int BHT_N = 1 << BHT_IDX_W;
  logic [HIST_W-1:0]    ghr_q, ghr_d;
  logic [HIST_W-1:0]    bht_q [BHT_N];
  logic [BHT_IDX_W-1:0] bidx_f, bidxd_q, bidxe_q;
  logic [HIST_W-1:0]    snap_f, snapd_q, snape_q;
  logic [PHT_IDX_W-1:0] idx_f, idxd_q, idxe_q;
  logic [1:0]           ctr_f, ctrd_q;
  logic                 moded_q, modee_q, vale_q, prede_q, btb_hitd, btb_bad_tgt;
  assign bidx_f = pcF[BHT_IDX_W+1:2];
  assign snap_f = (mode == MODE_GSHARE) ? ghr_q : bht_q[bidx_f];
  assign idx_f  = pcF[PHT_IDX_W+1:2] ^ PHT_IDX_W'(snap_f);
  bpu_pht #(.IDX_W(PHT_IDX_W)) u_pht (
    .clk(clk), .rst(rst), .ridx_i(idx_f), .rctr_o(ctr_f),
    .we_i(vale_q), .widx_i(idxe_q), .taken_i(actual_takeE)
  );
  assign pred_takeD  = branchD & ctrd_q[1] & btb_hitd;
  assign pred_takeE  = prede_q;
  assign mispredictE = vale_q & ((prede_q ^ actual_takeE) | btb_bad_tgt);
  // Repair outranks the speculative shift of a younger branch leaving D.
  always_comb begin
    ghr_d = mispredictE ? {snape_q[HIST_W-2:0], actual_takeE}
          : (branchD & ~stallD & ~flushD & ~flushE) ? {ghr_q[HIST_W-2:0], pred_takeD}
          : ghr_q;
  end
  always_ff @(posedge clk) begin
    if (!rst || flushD) begin
      ctrd_q  <= '0;
      idxd_q  <= '0;
      bidxd_q <= '0;
      snapd_q <= '0;
      moded_q <= 1'b0;
    end else if (!stallD) begin
      ctrd_q  <= ctr_f;
      idxd_q  <= idx_f;
      bidxd_q <= bidx_f;
      snapd_q <= snap_f;
      moded_q <= mode;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst || flushE) begin
      vale_q  <= 1'b0;
      prede_q <= 1'b0;
      idxe_q  <= '0;
      bidxe_q <= '0;
      snape_q <= '0;
      modee_q <= 1'b0;
    end else if (stallD) begin
      vale_q  <= 1'b0;
      prede_q <= 1'b0;
    end else begin
      vale_q  <= branchD;
      prede_q <= pred_takeD;
      idxe_q  <= idxd_q;
      bidxe_q <= bidxd_q;
      snape_q <= snapd_q;
      modee_q <= moded_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      ghr_q <= '0;
      for (int i = 0; i < BHT_N; i++) bht_q[i] <= '0;
    end else begin
      ghr_q <= ghr_d;
      if (vale_q && modee_q == MODE_LOCAL) bht_q[bidxe_q] <= {bht_q[bidxe_q][HIST_W-2:0], actual_takeE};
    end
  end
`ifdef BPU_BTB_EN
  localparam int BTB_N = 1 << BTB_IDX_W;
  localparam int TAG_W = 30 - BTB_IDX_W;
  logic                 btb_v_q   [BTB_N];
  logic [TAG_W-1:0]     btb_tag_q [BTB_N];
  logic [31:0]          btb_tgt_q [BTB_N];
  logic [BTB_IDX_W-1:0] bti_f, btid_q, btie_q;
  logic [TAG_W-1:0]     tag_f, tagd_q, tage_q;
  logic [31:0]          tgtd_q, tgte_q;
  logic                 hit_f, hitd_q;
  logic                 unused_bits;
  assign bti_f        = pcF[BTB_IDX_W+1:2];
  assign tag_f        = pcF[31:BTB_IDX_W+2];
  assign hit_f        = btb_v_q[bti_f] && btb_tag_q[bti_f] == tag_f;
  assign btb_hitd     = hitd_q;
  assign pred_hitD    = branchD & hitd_q;
  assign pred_targetD = tgtd_q;
  assign btb_bad_tgt  = prede_q & (tgte_q != targetE);
  assign unused_bits  = ^{pcF[1:0], ctrd_q[0], snape_q[HIST_W-1]};
  always_ff @(posedge clk) begin
    if (!rst || flushD) begin
      hitd_q <= 1'b0;
      tgtd_q <= '0;
      btid_q <= '0;
      tagd_q <= '0;
    end else if (!stallD) begin
      hitd_q <= hit_f;
      tgtd_q <= btb_tgt_q[bti_f];
      btid_q <= bti_f;
      tagd_q <= tag_f;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst || flushE) begin
      tgte_q <= '0;
      btie_q <= '0;
      tage_q <= '0;
    end else if (!stallD) begin
      tgte_q <= tgtd_q;
      btie_q <= btid_q;
      tage_q <= tagd_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < BTB_N; i++) btb_v_q[i] <= 1'b0;
    end else if (vale_q && actual_takeE) begin
      btb_v_q[btie_q]   <= 1'b1;
      btb_tag_q[btie_q] <= tage_q;
      btb_tgt_q[btie_q] <= targetE;
    end
  end
`else
  logic unused_bits;
  assign btb_hitd     = 1'b1;
  assign pred_hitD    = 1'b0;
  assign pred_targetD = '0;
  assign btb_bad_tgt  = 1'b0;
  assign unused_bits  = ^{targetE, pcF[31:PHT_IDX_W+2], pcF[BTB_IDX_W+1:0], ctrd_q[0], snape_q[HIST_W-1]};
`endif
endmodule

// File: tb/tb_branch_predict_gen.sv
// tb_branch_predict_gen: table-driven and hand-sequenced checks with an expected-result queue
module tb_branch_predict_gen;
  logic clk = 1'b0, rst = 1'b0, mode = 1'b0, stallD = 1'b0, flushD = 1'b0, flushE = 1'b0;
  logic branchD = 1'b0, actual_takeE = 1'b0;
  logic [31:0] pcF = '0, targetE = '0;
  logic pred_takeD, pred_hitD, pred_takeE, mispredictE;
  logic [31:0] pred_targetD;
  int n_vec = 0, n_fail = 0;
  typedef struct { logic act; logic pred; logic mis; } vec_t;
  typedef struct { logic chk; logic pred; logic mis; } exp_t;
  vec_t tbl [31];
  exp_t sbq [$];

  branch_predict_gen dut (
    .clk(clk), .rst(rst), .mode(mode), .pcF(pcF), .stallD(stallD), .flushD(flushD),
    .flushE(flushE), .branchD(branchD), .actual_takeE(actual_takeE), .targetE(targetE),
    .pred_takeD(pred_takeD), .pred_targetD(pred_targetD), .pred_hitD(pred_hitD),
    .pred_takeE(pred_takeE), .mispredictE(mispredictE)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; branchD = 1'b0; stallD = 1'b0; flushD = 1'b0; flushE = 1'b0;
    actual_takeE = 1'b0; pcF = '0; targetE = '0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // One isolated branch: F lookup, D prediction, E resolve.
  task automatic branch(input logic [31:0] pc, input logic md, input logic act, input logic [31:0] tgt,
                        input exp_t e, output logic hit, output logic [31:0] ptgt);
    exp_t r;
    pcF = pc; mode = md; branchD = 1'b0; actual_takeE = 1'b0;
    sbq.push_back(e);
    tick();
    branchD = 1'b1; pcF = 32'h0;
    #1;
    hit = pred_hitD; ptgt = pred_targetD;
    if (sbq[0].chk) check("pred_takeD", 32'(pred_takeD), 32'(sbq[0].pred));
    tick();
    branchD = 1'b0; actual_takeE = act; targetE = tgt;
    #1;
    r = sbq.pop_front();
    if (r.chk) begin
      check("mispredictE", 32'(mispredictE), 32'(r.mis));
      check("pred_takeE", 32'(pred_takeE), 32'(r.pred));
    end
    tick();
    actual_takeE = 1'b0; targetE = '0;
  endtask

  initial begin
    exp_t e;
    logic hit;
    logic [31:0] ptgt;
    logic a;
    // Single PC in local mode: history saturates at 0xFF, exposing counter hysteresis there.
    for (int i = 0; i < 31; i++) begin
      tbl[i].act  = !(i == 12 || i == 21 || i == 30);
      tbl[i].pred = (i >= 9 && i <= 12) || (i >= 20 && i <= 29);
      tbl[i].mis  = tbl[i].act ^ tbl[i].pred;
    end
    rst = 1'b0; pcF = 32'h100;
    tick();
    tick();
    branchD = 1'b1; actual_takeE = 1'b1;
    #1;
    check("reset_pred_takeD", 32'(pred_takeD), 32'h0);
    check("reset_pred_takeE", 32'(pred_takeE), 32'h0);
    check("reset_mispredictE", 32'(mispredictE), 32'h0);
    check("reset_pred_hitD", 32'(pred_hitD), 32'h0);
    check("reset_pred_targetD", pred_targetD, 32'h0);
    branchD = 1'b0; actual_takeE = 1'b0; rst = 1'b1;
`ifndef BPU_BTB_EN
    for (int i = 0; i < 31; i++) begin
      e = '{chk: 1'b1, pred: tbl[i].pred, mis: tbl[i].mis};
      branch(32'h100, 1'b0, tbl[i].act, 32'h0, e, hit, ptgt);
    end
    check("nobtb_hit", 32'(hit), 32'h0);
    check("nobtb_target", ptgt, 32'h0);
    // Stall with a taken-predicted branch in D while F looks at a not-taken PC.
    pcF = 32'h100; mode = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      branchD = 1'b1; stallD = 1'b1; pcF = 32'h0; actual_takeE = 1'b0;
      #1;
      check("stall_pred_takeD", 32'(pred_takeD), 32'h1);
      check("stall_bubble_mis", 32'(mispredictE), 32'h0);
      tick();
    end
    stallD = 1'b0;
    #1;
    check("unstall_pred_takeD", 32'(pred_takeD), 32'h1);
    tick();
    branchD = 1'b0; actual_takeE = 1'b1;
    #1;
    check("stall_resolve_mis", 32'(mispredictE), 32'h0);
    check("stall_resolve_predE", 32'(pred_takeE), 32'h1);
    tick();
    actual_takeE = 1'b0;
    check("stall_ghr_one_shift", 32'(dut.ghr_q), 32'hFD);
    // flushD clears a lookup that would otherwise predict taken.
    pcF = 32'h100; flushD = 1'b1;
    tick();
    flushD = 1'b0; branchD = 1'b1; stallD = 1'b1; pcF = 32'h0;
    #1;
    check("flushD_pred_takeD", 32'(pred_takeD), 32'h0);
    tick();
    branchD = 1'b0; stallD = 1'b0;
    // Gshare: E mispredict repairs GHR over a same-cycle younger branch shift.
    do_reset();
    pcF = 32'h200; mode = 1'b1;
    tick();
    branchD = 1'b1; pcF = 32'h300;
    #1;
    check("gs_A_pred_takeD", 32'(pred_takeD), 32'h0);
    tick();
    branchD = 1'b1; pcF = 32'h0; actual_takeE = 1'b1;
    #1;
    check("gs_A_mispredictE", 32'(mispredictE), 32'h1);
    check("gs_B_pred_takeD", 32'(pred_takeD), 32'h0);
    tick();
    check("gs_ghr_repair", 32'(dut.ghr_q), 32'h01);
    branchD = 1'b0; actual_takeE = 1'b0;
    #1;
    check("gs_B_mispredictE", 32'(mispredictE), 32'h0);
    tick();
    check("gs_ghr_after_B", 32'(dut.ghr_q), 32'h01);
    // Local mode learns an alternating pattern after the history fills.
    for (int k = 0; k < 20; k++) begin
      a = (k % 2 == 0);
      e = '{chk: (k >= 9), pred: a, mis: 1'b0};
      branch(32'h500, 1'b0, a, 32'h0, e, hit, ptgt);
    end
`else
    do_reset();
    e = '{chk: 1'b0, pred: 1'b0, mis: 1'b0};
    branch(32'h100, 1'b0, 1'b1, 32'h400, e, hit, ptgt);
    check("btb_cold_hit", 32'(hit), 32'h0);
    branch(32'h100, 1'b0, 1'b1, 32'h400, e, hit, ptgt);
    check("btb_warm_hit", 32'(hit), 32'h1);
    check("btb_warm_target", ptgt, 32'h400);
    branch(32'h200, 1'b0, 1'b0, 32'h0, e, hit, ptgt);
    check("btb_tag_miss", 32'(hit), 32'h0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_predict_gen.md
Name: branch_predict_gen

Overview:
- Parametrised dynamic branch predictor for the 5-stage MIPS pipeline; next generation of the current fixed branch predictor.
- Looks up a 2-bit saturating-counter PHT with pcF and presents the registered prediction in D.
- Tracks each branch to E, flags mispredicts there, and trains the tables.
- Runtime-selectable local-history or gshare indexing; speculative global history with repair on mispredict.

Parameters:
- PHT_IDX_W, 10, log2 PHT entries (1024 x 2-bit counters).
- BHT_IDX_W, 8, log2 local history table entries.
- HIST_W, 8, history length; must be <= PHT_IDX_W.
- BTB_IDX_W, 6, log2 BTB entries (used only with BPU_BTB_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- mode  in  1  0 = local history, 1 = gshare; sampled per lookup.
- pcF  in  32  fetch PC.
- stallD  in  1  hold the D-stage registers.
- flushD  in  1  clear the D-stage registers.
- flushE  in  1  clear the E-stage registers.
- branchD  in  1  instruction in D is a conditional branch.
- actual_takeE  in  1  resolved outcome of the E-stage branch.
- targetE  in  32  resolved target of the E-stage branch.
- pred_takeD  out  1  predicted direction for D; 0 when branchD = 0.
- pred_targetD  out  32  BTB target (BPU_BTB_EN only).
- pred_hitD  out  1  BTB tag hit (BPU_BTB_EN only).
- pred_takeE  out  1  prediction carried to E.
- mispredictE  out  1  combinational mispredict flag for the E-stage branch.

Behaviour:
- Reset (rst = 0 at an edge): every PHT counter = 2'b01 (weakly not-taken); BHT entries and GHR = 0; BTB valid bits = 0; all pipeline registers = 0. Outputs read 0 in the cycle after reset. Reset mid-flight drops any pending update.
- PC index: pcidx = pcF[PHT_IDX_W+1:2].
- Local mode: h = BHT[pcF[BHT_IDX_W+1:2]]; PHT index = pcidx XOR zero-extended h.
- Gshare mode: PHT index = pcidx XOR zero-extended GHR.
- Lookup latency is 1 cycle. In F, counter, index, history snapshot and mode are read. They are registered into D when stallD = 0, held when stallD = 1, and zeroed when flushD = 1 (flushD has priority).
- pred_takeD = branchD AND counter[1].
- D to E: branch valid, pred_take, PHT index, BHT index, history snapshot and mode advance only when stallD = 0. When stallD = 1 a bubble (valid = 0) enters E. flushE zeroes the E registers.
- Speculative GHR: when a valid branch leaves D (branchD, no stall, no flush), GHR <= {GHR[HIST_W-2:0], pred_takeD}. An instruction fetched immediately behind a D branch sees the unshifted GHR; this is accepted behaviour.
- mispredictE = validE AND (pred_takeE XOR actual_takeE).
- Repair: on mispredictE, GHR <= {snapE[HIST_W-2:0], actual_takeE}. Repair has priority over a same-cycle speculative shift.
- Training at the end of E when validE = 1:
  - PHT[idxE] saturates: taken increments to a maximum of 3; not-taken decrements to a minimum of 0.
  - Local mode also shifts actual_takeE into BHT[bidxE].
  - Counters never wrap.
- Read/write collision on the same PHT entry in one cycle: the read returns the old value (no bypass).

Optional Feature:
- BPU_BTB_EN defined:
  - Direct-mapped BTB of 2^BTB_IDX_W entries, each {valid, tag = pcF[31:BTB_IDX_W+2], target}, read in F and registered to D.
  - pred_hitD = branchD AND hit; pred_targetD = stored target.
  - pred_takeD additionally requires a hit.
  - Allocation or update on a taken resolve in E.
  - mispredictE also asserts when pred_takeE = 1 and the stored target differs from targetE.
- Undefined: no BTB storage; pred_hitD = 0 and pred_targetD = 0; mispredict is direction-only.

Decomposition:
- Package bpu_pkg holds:
  - MODE_LOCAL = 0 and MODE_GSHARE = 1;
  - counter encodings SNT = 0, WNT = 1, WT = 2, ST = 3;
  - a function sat_update(ctr, taken).
- Sub-module bpu_pht: 2-bit counter array with one asynchronous read port, one synchronous write port and the synchronous reset init. Instantiated once.

Test Plan:
- Reset, then a branch at pcF = 0x100 → pred_takeD = 0; after two taken resolves the counter goes 1→2→3 and the next lookup gives pred_takeD = 1.
- Branch resolves taken 4x, then not-taken 1x → counter 3→2; pred_takeD stays 1 (hysteresis). A second not-taken → pred_takeD = 0.
- Gshare with GHR = 0x00, predicted not-taken but actual taken → mispredictE = 1 and GHR = 0x01 the next cycle, even with a simultaneous branchD.
- stallD = 1 for 3 cycles with a branch in D → pred_takeD held; validE = 0 bubbles; no extra GHR shift.
- Local mode: alternating T/N pattern at one PC for 20 iterations → zero mispredicts after warm-up.
- BPU_BTB_EN: taken branch to 0x400, revisited → pred_hitD = 1 and pred_targetD = 0x400. Same index with a different tag → pred_hitD = 0.
